program_counter_rs: RTL and testbench

Parametrised next-generation program counter for the i281 CPU datapath. It generalises the load/hold PC with these additions:
- sequential increment
- absolute jump and PC-relative branch, both conditional
- call/return through an internal return-address stack of configurable depth
- a stall input
- status flags for stack faults

It sits between the control unit (Op/Cond/Stall) and the instruction memory address bus (PC_Output).

---
 rtl/program_counter_rs.sv | 112 +++++++++++
 tb/tb_program_counter_rs.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_counter_rs.sv
// Program counter with increment, jump/branch, a call/return stack and sticky fault flags.
// Every output comes straight from a register, so nothing passes combinationally from input to output.
module program_counter_rs #(
    parameter int             N           = 6,
    parameter int             STACK_DEPTH = 4,
    parameter logic [N-1:0]   RESET_ADDR  = '0
) (
    input  logic                               Clock,
    input  logic                               Reset_n,
    input  logic                               Stall,
    input  logic [2:0]                         Op,
    input  logic                               Cond,
    input  logic [N-1:0]                       PC_Input,
    input  logic [N-1:0]                       Offset,
    input  logic                               Clear_Flags,
    output logic [N-1:0]                       PC_Output,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   Stack_Count,
    output logic                               Stack_Overflow,
    output logic                               Stack_Underflow,
    output logic                               Illegal_Op
);

    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [N-1:0]  pc, pc_n, pc_inc;
    logic [CW-1:0] cnt, cnt_n;
    logic          ovf, ovf_n;
    logic          unf, unf_n;
    logic          ill, ill_n;
    logic          push;
    logic          full, empty;
    logic [AW-1:0] wr_idx, rd_idx;
    logic [N-1:0]  stack [STACK_DEPTH];

    assign pc_inc = pc + N'(1);
    assign full   = (cnt == CW'(STACK_DEPTH));
    assign empty  = (cnt == '0);
    assign wr_idx = AW'(cnt);
    assign rd_idx = AW'(cnt - CW'(1));

    always_comb begin
        pc_n  = pc;
        cnt_n = cnt;
        ovf_n = ovf;
        unf_n = unf;
        ill_n = 1'b0;
        push  = 1'b0;
        if (!Stall) begin
            // Clearing first lets a fault in the same cycle win.
            if (Clear_Flags) begin
                ovf_n = 1'b0;
                unf_n = 1'b0;
            end
            unique case (Op)
                3'b000: pc_n = pc;
                3'b001: pc_n = pc_inc;
                3'b010: pc_n = Cond ? PC_Input : pc_inc;
                3'b011: pc_n = Cond ? pc_inc + Offset : pc_inc;
                3'b100: begin
                    pc_n = PC_Input;
                    if (full) begin
                        ovf_n = 1'b1;
                    end else begin
                        push  = 1'b1;
                        cnt_n = cnt + CW'(1);
                    end
                end
                3'b101: begin
                    if (empty) begin
                        pc_n  = pc_inc;
                        unf_n = 1'b1;
                    end else begin
                        pc_n  = stack[rd_idx];
                        cnt_n = cnt - CW'(1);
                    end
                end
                default: ill_n = 1'b1;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pc  <= RESET_ADDR;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
            ill <= 1'b0;
        end else begin
            pc  <= pc_n;
            cnt <= cnt_n;
            ovf <= ovf_n;
            unf <= unf_n;
            ill <= ill_n;
        end
    end

    // Stack contents carry no reset; only the count defines validity.
    always_ff @(posedge Clock) begin
        if (push) begin
            stack[wr_idx] <= pc_inc;
        end
    end

    assign PC_Output       = pc;
    assign Stack_Count     = cnt;
    assign Stack_Overflow  = ovf;
    assign Stack_Underflow = unf;
    assign Illegal_Op      = ill;

endmodule

// File: tb/tb_program_counter_rs.sv
// Directed bench for program_counter_rs with a queue-based reference model
// and a scoreboard of expected post-edge states.
module tb_program_counter_rs;

    localparam int N     = 6;
    localparam int DEPTH = 4;

    logic         Clock = 1'b0;
    logic         Reset_n = 1'b0;
    logic         Stall = 1'b0;
    logic [2:0]   Op = 3'b000;
    logic         Cond = 1'b0;
    logic [N-1:0] PC_Input = '0;
    logic [N-1:0] Offset = '0;
    logic         Clear_Flags = 1'b0;
    logic [N-1:0] PC_Output;
    logic [2:0]   Stack_Count;
    logic         Stack_Overflow;
    logic         Stack_Underflow;
    logic         Illegal_Op;

    program_counter_rs #(.N(N), .STACK_DEPTH(DEPTH), .RESET_ADDR(6'h00)) dut (
        .Clock(Clock),
        .Reset_n(Reset_n),
        .Stall(Stall),
        .Op(Op),
        .Cond(Cond),
        .PC_Input(PC_Input),
        .Offset(Offset),
        .Clear_Flags(Clear_Flags),
        .PC_Output(PC_Output),
        .Stack_Count(Stack_Count),
        .Stack_Overflow(Stack_Overflow),
        .Stack_Underflow(Stack_Underflow),
        .Illegal_Op(Illegal_Op)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [N-1:0] pc;
        logic [2:0]   cnt;
        logic         ovf;
        logic         unf;
        logic         ill;
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] m_stk[$];
    logic [N-1:0] m_pc = '0;
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;
    logic         m_ill = 1'b0;
    int           vectors = 0;
    int           miscompares = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = 6'h00;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_ill = 1'b0;
    endtask

    task automatic apply(input string tag, input logic [2:0] op, input logic cond,
                         input logic [N-1:0] inp, input logic [N-1:0] off,
                         input logic stall, input logic clr);
        exp_t         e;
        exp_t         got;
        logic [N-1:0] nxt;
        Op = op; Cond = cond; PC_Input = inp; Offset = off;
        Stall = stall; Clear_Flags = clr;
        nxt = m_pc + 6'd1;
        m_ill = 1'b0;
        if (!stall) begin
            if (clr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            case (op)
                3'd0: ;
                3'd1: m_pc = nxt;
                3'd2: m_pc = cond ? inp : nxt;
                3'd3: m_pc = cond ? nxt + off : nxt;
                3'd4: begin
                    if (m_stk.size() == DEPTH) m_ovf = 1'b1;
                    else m_stk.push_back(nxt);
                    m_pc = inp;
                end
                3'd5: begin
                    if (m_stk.size() == 0) begin
                        m_unf = 1'b1;
                        m_pc  = nxt;
                    end else begin
                        m_pc = m_stk.pop_back();
                    end
                end
                default: m_ill = 1'b1;
            endcase
        end
        e.pc  = m_pc;
        e.cnt = 3'(m_stk.size());
        e.ovf = m_ovf;
        e.unf = m_unf;
        e.ill = m_ill;
        sb.push_back(e);
        @(posedge Clock);
        #1;
        got = sb.pop_front();
        check({tag, ".pc"},  8'(PC_Output),       8'(got.pc));
        check({tag, ".cnt"}, 8'(Stack_Count),     8'(got.cnt));
        check({tag, ".ovf"}, 8'(Stack_Overflow),  8'(got.ovf));
        check({tag, ".unf"}, 8'(Stack_Underflow), 8'(got.unf));
        check({tag, ".ill"}, 8'(Illegal_Op),      8'(got.ill));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #12;
        check("rst.pc",  8'(PC_Output), 8'h00);
        check("rst.cnt", 8'(Stack_Count), 8'h00);
        check("rst.ovf", 8'(Stack_Overflow), 8'h0);
        check("rst.unf", 8'(Stack_Underflow), 8'h0);
        check("rst.ill", 8'(Illegal_Op), 8'h0);
        @(negedge Clock);
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;

        // increment wrap and hold
        apply("jmp3e", 3'd2, 1'b1, 6'h3E, 6'h00, 1'b0, 1'b0);
        apply("inc1",  3'd1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        check("inc1.k", 8'(PC_Output), 8'h3F);
        apply("inc2",  3'd1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        check("inc2.k", 8'(PC_Output), 8'h00);
        apply("inc3",  3'd1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        check("inc3.k", 8'(PC_Output), 8'h01);
        apply("hold1", 3'd0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        apply("hold2", 3'd0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        check("hold2.k", 8'(PC_Output), 8'h01);

        // branches and jumps
        apply("jmp10", 3'd2, 1'b1, 6'h10, 6'h00, 1'b0, 1'b0);
        apply("brt",   3'd3, 1'b1, 6'h00, 6'h3C, 1'b0, 1'b0);
        check("brt.k", 8'(PC_Output), 8'h0D);
        apply("brn",   3'd3, 1'b0, 6'h00, 6'h3C, 1'b0, 1'b0);
        check("brn.k", 8'(PC_Output), 8'h0E);
        apply("jmpn",  3'd2, 1'b0, 6'h33, 6'h00, 1'b0, 1'b0);
        apply("jmp05", 3'd2, 1'b1, 6'h05, 6'h00, 1'b0, 1'b0);
        check("jmp05.k", 8'(PC_Output), 8'h05);

        // call/return stack with overflow and underflow
        apply("jmp00", 3'd2, 1'b1, 6'h00, 6'h00, 1'b0, 1'b0);
        apply("call1", 3'd4, 1'b0, 6'h10, 6'h00, 1'b0, 1'b0);
        apply("call2", 3'd4, 1'b0, 6'h20, 6'h00, 1'b0, 1'b0);
        apply("call3", 3'd4, 1'b0, 6'h30, 6'h00, 1'b0, 1'b0);
        apply("call4", 3'd4, 1'b0, 6'h38, 6'h00, 1'b0, 1'b0);
        check("call4.cnt", 8'(Stack_Count), 8'd4);
        apply("call5", 3'd4, 1'b0, 6'h08, 6'h00, 1'b0, 1'b0);
        check("call5.pc",  8'(PC_Output), 8'h08);
        check("call5.ovf", 8'(Stack_Overflow), 8'h1);
        apply("ret1", 3'd5, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        check("ret1.k", 8'(PC_Output), 8'h31);
        apply("ret2", 3'd5, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        apply("ret3", 3'd5, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        apply("ret4", 3'd5, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        check("ret4.k", 8'(PC_Output), 8'h01);
        apply("ret5", 3'd5, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        check("ret5.pc",  8'(PC_Output), 8'h02);
        check("ret5.unf", 8'(Stack_Underflow), 8'h1);
        apply("clr",  3'd0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b1);

        // reserved ops, stall behaviour
        apply("ill",   3'd6, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        check("ill.k", 8'(Illegal_Op), 8'h1);
        apply("ill0",  3'd0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        apply("ill7",  3'd7, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        apply("illst", 3'd6, 1'b0, 6'h00, 6'h00, 1'b1, 1'b0);
        apply("stcal", 3'd4, 1'b0, 6'h2C, 6'h00, 1'b1, 1'b0);
        apply("call6", 3'd4, 1'b0, 6'h2C, 6'h00, 1'b0, 1'b0);
        apply("stret", 3'd5, 1'b0, 6'h00, 6'h00, 1'b1, 1'b1);
        apply("ret6",  3'd5, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        apply("clrun", 3'd5, 1'b0, 6'h00, 6'h00, 1'b0, 1'b1);
        check("clrun.k", 8'(Stack_Underflow), 8'h1);
        apply("stclr", 3'd0, 1'b0, 6'h00, 6'h00, 1'b1, 1'b1);
        apply("clr2",  3'd0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b1);
        check("clr2.k", 8'(Stack_Underflow), 8'h0);

        // asynchronous reset in the middle of activity
        apply("mj10", 3'd2, 1'b1, 6'h10, 6'h00, 1'b0, 1'b0);
        apply("mc20", 3'd4, 1'b0, 6'h20, 6'h00, 1'b0, 1'b0);
        apply("mc29", 3'd4, 1'b0, 6'h29, 6'h00, 1'b0, 1'b0);
        apply("minc", 3'd1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        check("mid.pc",  8'(PC_Output), 8'h2A);
        check("mid.cnt", 8'(Stack_Count), 8'd2);
        Op = 3'd1;
        #2;
        Reset_n = 1'b0;
        #1;
        check("arst.pc",  8'(PC_Output), 8'h00);
        check("arst.cnt", 8'(Stack_Count), 8'd0);
        model_reset();
        @(negedge Clock);
        Reset_n = 1'b1;
        #1;
        apply("post", 3'd0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
        check("post.k", 8'(PC_Output), 8'h00);
        apply("postinc", 3'd1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
